alu_op_sequencer: RTL and testbench

- Command-side initiator for the 4-bit combinational ALU.
- Accepts operand/function commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's a/b/function inputs from registers, samples the ALU result, and returns it in order on a valid/ready response channel with zero and error flags.
- Sits between the control/test logic and the ALU instance.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_cmd_fifo.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes, sequencer states and command entry layout {chain, func, b, a}.
package alu_pkg;
  localparam int FUNC_W = 3;
  localparam logic [FUNC_W-1:0] FN_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] FN_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] FN_AND = 3'd2;
  localparam logic [FUNC_W-1:0] FN_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] FN_XOR = 3'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2} state_t;
  function automatic int entry_w(input int data_w, input bit chain);
    return int'(chain) + FUNC_W + 2 * data_w;
  endfunction
  function automatic logic is_illegal(input logic [FUNC_W-1:0] func);
    return func > FN_XOR;
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous first-word-fall-through command FIFO with async active-high reset.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, drives the ALU from registers and returns results in order.
// Optional result chaining (alu_a <= previous result) is enabled by ALU_OP_SEQUENCER_CHAIN_EN.
module alu_op_sequencer import alu_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [FUNC_W-1:0] cmd_func,
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
  input  logic              cmd_chain,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_function,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
  localparam int EW = entry_w(DATA_W, 1'b1);
`else
  localparam int EW = entry_w(DATA_W, 1'b0);
`endif
  state_t state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
  logic [FUNC_W-1:0] alu_function_q, alu_function_d;
  logic err_q, err_d, rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [EW-1:0] fifo_din, fifo_dout;
  logic fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] head_a, head_b, issue_a;
  logic [FUNC_W-1:0] head_func;
  assign head_a    = fifo_dout[DATA_W-1:0];
  assign head_b    = fifo_dout[2*DATA_W-1:DATA_W];
  assign head_func = fifo_dout[2*DATA_W +: FUNC_W];
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
  logic [DATA_W-1:0] last_result_q, last_result_d;
  assign fifo_din      = {cmd_chain, cmd_func, cmd_b, cmd_a};
  assign issue_a       = fifo_dout[EW-1] ? last_result_q : head_a;
  assign last_result_d = state_q == DRIVE ? alu_result : last_result_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_result_q <= '0;
    else last_result_q <= last_result_d;
  end
`else
  assign fifo_din = {cmd_func, cmd_b, cmd_a};
  assign issue_a  = head_a;
`endif
  alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk(clk), .reset(reset), .push(cmd_valid), .pop(fifo_pop), .din(fifo_din),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
  // Issue from IDLE, or straight from RESP when the consumer takes the response.
  assign fifo_pop = !fifo_empty && (state_q == IDLE || (state_q == RESP && rsp_ready));
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_function_d = alu_function_q;
    err_d          = err_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_err_d      = rsp_err_q;
    if (fifo_pop) begin
      alu_a_d        = issue_a;
      alu_b_d        = head_b;
      alu_function_d = head_func;
      err_d          = is_illegal(head_func);
    end
    if (state_q == DRIVE) begin
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_result == '0;
      rsp_err_d    = err_q;
      rsp_valid_d  = 1'b1;
    end
    if (state_q == RESP && rsp_ready) rsp_valid_d = 1'b0;
    state_d = fifo_pop ? DRIVE : state_q == DRIVE ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_function_q <= '0;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_function_q <= alu_function_d;
      err_q          <= err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_err_q      <= rsp_err_d;
    end
  end
  assign cmd_ready    = !fifo_full;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_function = alu_function_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = state_q != IDLE || !fifo_empty;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed checks of alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_zero, rsp_err, busy;
  logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] cmd_func = 0, alu_function;
  logic cmd_chain = 0;
  int tests = 0, fails = 0, cyc = 0, last_res = 0;
  typedef struct {logic [3:0] r; logic z; logic e;} rsp_t;
  rsp_t exp_q[$], got_q[$];
  int got_cyc[$];

  always #5 clk = ~clk;

  always_comb begin
    case (alu_function)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = 4'd0;
    endcase
  end

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_function(alu_function), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid && rsp_ready) begin
      got_q.push_back('{rsp_result, rsp_zero, rsp_err});
      got_cyc.push_back(cyc);
    end
  end

  function automatic rsp_t model(input int a, input int b, input int f);
    int r;
    case (f)
      0: r = (a + b) % 16;
      1: r = (a - b + 16) % 16;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      default: r = 0;
    endcase
    return '{4'(r), r == 0, f > 4};
  endfunction

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic push_cmd(input int a, input int b, input int f, input bit ch);
    int n = 0;
    rsp_t e;
    cmd_a = 4'(a); cmd_b = 4'(b); cmd_func = 3'(f); cmd_chain = ch; cmd_valid = 1;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    tests++;
    if (!cmd_ready) begin
      fails++; $display("FAIL push_timeout cmd_ready=%b want 1", cmd_ready);
    end else begin
      @(posedge clk);
      e = model(ch ? last_res : a, b, f);
      exp_q.push_back(e);
      last_res = int'(e.r);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (got_q.size() < n && k < 400) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    @(negedge clk);
    clear_q(); last_res = 0;
    tests++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      fails++; $display("FAIL reset_ctrl ready/busy/valid=%b want 100", {cmd_ready, busy, rsp_valid});
    end
    tests++;
    if ({rsp_result, rsp_zero, rsp_err} !== 6'd0) begin
      fails++; $display("FAIL reset_rsp got=%h want 0", {rsp_result, rsp_zero, rsp_err});
    end
    tests++;
    if ({alu_a, alu_b, alu_function} !== 11'd0) begin
      fails++; $display("FAIL reset_alu got=%h want 0", {alu_a, alu_b, alu_function});
    end
  endtask

  task automatic test_latency();
    rsp_ready = 1;
    cmd_a = 3; cmd_b = 4; cmd_func = 0; cmd_chain = 0; cmd_valid = 1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 0;
    tests++;
    if ({rsp_valid, busy} !== 2'b01) begin
      fails++; $display("FAIL lat_n valid/busy=%b want 01", {rsp_valid, busy});
    end
    @(negedge clk);
    tests++;
    if ({alu_a, alu_b, alu_function, rsp_valid} !== {4'd3, 4'd4, 3'd0, 1'b0}) begin
      fails++; $display("FAIL lat_n1 a=%h b=%h f=%h valid=%b want 3 4 0 0", alu_a, alu_b, alu_function, rsp_valid);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
      fails++; $display("FAIL lat_n2 valid=%b res=%h z=%b e=%b want 1 7 0 0", rsp_valid, rsp_result, rsp_zero, rsp_err);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL lat_n3 valid/busy=%b want 00", {rsp_valid, busy});
    end
    clear_q();
    last_res = 7;
  endtask

  task automatic test_wrap_zero();
    int ta[5] = '{2, 9, 12, 12, 15};
    int tb[5] = '{5, 7, 10, 3, 5};
    int tf[5] = '{1, 0, 2, 3, 4};
    int wr[5] = '{13, 0, 8, 15, 10};
    int wz[5] = '{0, 1, 0, 0, 0};
    rsp_ready = 1; clear_q();
    for (int i = 0; i < 5; i++) push_cmd(ta[i], tb[i], tf[i], 0);
    wait_rsp(5);
    tests++;
    if (got_q.size() != 5) begin fails++; $display("FAIL wrap_count got=%0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].r, got_q[i].z, got_q[i].e} !== {4'(wr[i]), 1'(wz[i]), 1'b0}) begin
        fails++; $display("FAIL wrap_%0d res=%h z=%b e=%b want %h %0d 0", i, got_q[i].r, got_q[i].z, got_q[i].e, wr[i], wz[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 0; clear_q();
    for (int i = 0; i < 5; i++) push_cmd(i + 1, 2 * i + 3, i, 0);
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_full cmd_ready=%b want 0", cmd_ready); end
    cmd_a = 4'hE; cmd_b = 4'h1; cmd_func = 3'd0; cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err} !== {1'b0, 1'b1, exp_q[0].r, exp_q[0].z, exp_q[0].e}) begin
        fails++; $display("FAIL bp_hold_%0d ready=%b valid=%b res=%h want 0 1 %h", i, cmd_ready, rsp_valid, rsp_result, exp_q[0].r);
      end
    end
    cmd_valid = 0;
    rsp_ready = 1;
    wait_rsp(5);
    repeat (6) @(negedge clk);
    tests++;
    if (got_q.size() != 5) begin fails++; $display("FAIL bp_count got=%0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] != exp_q[i]) begin
        fails++; $display("FAIL bp_order_%0d res=%h want %h", i, got_q[i].r, exp_q[i].r);
      end
      if (i > 0) begin
        tests++;
        if (got_cyc[i] - got_cyc[i-1] != 2) begin
          fails++; $display("FAIL bp_gap_%0d gap=%0d want 2", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    rsp_ready = 1; clear_q();
    push_cmd(5, 5, 6, 0);
    wait_rsp(1);
    tests++;
    if (got_q.size() != 1 || {got_q[0].r, got_q[0].z, got_q[0].e} !== {4'd0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL illegal n=%0d res/z/e=%h want 0 1 1", got_q.size(), got_q.size() ? {got_q[0].r, got_q[0].z, got_q[0].e} : 6'h3f);
    end
  endtask

  task automatic test_random();
    int n = 40;
    clear_q();
    fork
      for (int i = 0; i < n; i++) begin
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
        push_cmd($urandom % 16, $urandom % 16, $urandom % 8, 1'($urandom % 2));
`else
        push_cmd($urandom % 16, $urandom % 16, $urandom % 8, 0);
`endif
        repeat ($urandom % 3) @(negedge clk);
      end
      begin
        int k = 0;
        while (got_q.size() < n && k < 3000) begin @(negedge clk); rsp_ready = 1'($urandom % 2); k++; end
        rsp_ready = 1;
      end
    join
    wait_rsp(n);
    tests++;
    if (got_q.size() != n) begin fails++; $display("FAIL rand_count got=%0d want %0d", got_q.size(), n); end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] != exp_q[i]) begin
        fails++; $display("FAIL rand_%0d res=%h z=%b e=%b want %h %b %b", i, got_q[i].r, got_q[i].z, got_q[i].e, exp_q[i].r, exp_q[i].z, exp_q[i].e);
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0; clear_q();
    for (int i = 0; i < 4; i++) push_cmd(i + 2, 1, 0, 0);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre valid=%b want 1", rsp_valid); end
    #2 reset = 1;
    #1;
    tests++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      fails++; $display("FAIL rmid_async valid/busy/ready=%b want 001", {rsp_valid, busy, cmd_ready});
    end
    @(negedge clk); reset = 0;
    clear_q(); last_res = 0;
    rsp_ready = 1;
    repeat (10) @(negedge clk);
    tests++;
    if (got_q.size() != 0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_quiet rsps=%0d valid=%b want 0 0", got_q.size(), rsp_valid);
    end
    push_cmd(6, 7, 0, 0);
    wait_rsp(1);
    tests++;
    if (got_q.size() != 1 || got_q[0].r !== 4'd13) begin
      fails++; $display("FAIL rmid_after n=%0d res=%h want 1 d", got_q.size(), got_q.size() ? got_q[0].r : 4'hx);
    end
  endtask

`ifdef ALU_OP_SEQUENCER_CHAIN_EN
  task automatic test_chain();
    int want[3] = '{3, 6, 5};
    rsp_ready = 1; clear_q();
    push_cmd(1, 2, 0, 0);
    push_cmd(9, 3, 0, 1);
    push_cmd(9, 1, 1, 1);
    wait_rsp(3);
    tests++;
    if (got_q.size() != 3) begin fails++; $display("FAIL chain_count got=%0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].r !== 4'(want[i])) begin
        fails++; $display("FAIL chain_%0d res=%h want %0d", i, got_q[i].r, want[i]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_wrap_zero();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
    test_chain();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
